// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mm_pkg
// Description : Shared types and constants for the 2x2 matrix-multiply sequencer.
// Revision    : 1.0  initial release
// ============================================================================
package mm_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_MAC   = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Result elements are visited in row-major order 00,01,10,11
    localparam logic [1:0] IDX_FIRST = 2'd0;
    localparam logic [1:0] IDX_LAST  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mac_unit.sv
`default_nettype none
// ============================================================================
// Module      : mac_unit
// Description : Shared unsigned multiply-accumulate with wrap detection.
// Revision    : 1.0  initial release
// ============================================================================
module mac_unit
    import mm_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clr,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc,
    output logic              ovf_pulse
);

    logic [2*DATA_W-1:0] w_prod;
    logic [ACC_W:0]      w_sum;

    assign w_prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    // Extra top bit of the sum is the carry out of the accumulator
    assign w_sum  = {1'b0, acc} + {{(ACC_W + 1 - 2*DATA_W){1'b0}}, w_prod};

    assign ovf_pulse = en & ~clr & w_sum[ACC_W];

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= w_sum[ACC_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/mm2x2_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mm2x2_sequencer
// Description : 2x2 unsigned matrix product through one time-shared MAC.
// Revision    : 1.0  initial release
// ============================================================================
module mm2x2_sequencer
    import mm_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                start,
    input  logic [4*DATA_W-1:0] a_flat,
    input  logic [4*DATA_W-1:0] b_flat,
    output logic                busy,
    output logic                done,
    output logic                c_valid,
    output logic [1:0]          c_idx,
    output logic [ACC_W-1:0]    c_data,
    output logic [ACC_W-1:0]    mac_output,
    output logic                ovf,
    output logic [4*ACC_W-1:0]  c_flat
);

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_idx;
    logic                r_k;
    logic [4*DATA_W-1:0] r_a;
    logic [4*DATA_W-1:0] r_b;
    logic [4*ACC_W-1:0]  r_c;
    logic                r_ovf;

    logic [DATA_W-1:0]   w_a_sel;
    logic [DATA_W-1:0]   w_b_sel;
    logic [ACC_W-1:0]    w_acc;
    logic                w_ovf_pulse;
    logic                w_mac_en;
    logic                w_mac_clr;

    // a[i][k] sits at element 2i+k, b[k][j] at element 2k+j
    assign w_a_sel   = r_a[DATA_W*{r_idx[1], r_k} +: DATA_W];
    assign w_b_sel   = r_b[DATA_W*{r_k, r_idx[0]} +: DATA_W];
    assign w_mac_en  = enable && (r_state == ST_MAC);
    assign w_mac_clr = enable && (r_state == ST_CLEAR);

    mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk       (clk),
        .reset     (reset),
        .en        (w_mac_en),
        .clr       (w_mac_clr),
        .a         (w_a_sel),
        .b         (w_b_sel),
        .acc       (w_acc),
        .ovf_pulse (w_ovf_pulse)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else if (enable) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_CLEAR;
            ST_CLEAR: w_next = ST_MAC;
            ST_MAC:   if (r_k) w_next = ST_WRITE;
            ST_WRITE: w_next = (r_idx == IDX_LAST) ? ST_DONE : ST_CLEAR;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_c   <= '0;
            r_idx <= IDX_FIRST;
            r_k   <= 1'b0;
            r_ovf <= 1'b0;
        end else if (enable) begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a   <= a_flat;
                        r_b   <= b_flat;
                        r_c   <= '0;
                        r_idx <= IDX_FIRST;
                        r_ovf <= 1'b0;
                    end
                end
                ST_CLEAR: r_k <= 1'b0;
                ST_MAC: begin
                    r_k <= 1'b1;
                    if (w_ovf_pulse) r_ovf <= 1'b1;
                end
                ST_WRITE: begin
                    r_c[ACC_W*r_idx +: ACC_W] <= w_acc;
                    r_idx                     <= r_idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy    = (r_state != ST_IDLE);
        done    = enable && (r_state == ST_DONE);
        c_valid = enable && (r_state == ST_WRITE);
        c_idx   = c_valid ? r_idx : 2'd0;
        c_data  = c_valid ? w_acc : '0;
    end

    assign mac_output = w_acc;
    assign ovf        = r_ovf;
    assign c_flat     = r_c;

endmodule
`default_nettype wire

// File: tb/tb_mm2x2_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mm2x2_sequencer
// Description : Directed and random jobs against a matrix-product/schedule model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mm2x2_sequencer;

    localparam int DW = 8;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b1;
    logic          start = 1'b0;
    logic [4*DW-1:0] a_flat = '0;
    logic [4*DW-1:0] b_flat = '0;
    logic          busy, done, c_valid, ovf;
    logic [1:0]    c_idx;
    logic [AW-1:0] c_data, mac_output;
    logic [4*AW-1:0] c_flat;

    int checks = 0;
    int errors = 0;

    mm2x2_sequencer #(.DATA_W(DW), .ACC_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .start      (start),
        .a_flat     (a_flat),
        .b_flat     (b_flat),
        .busy       (busy),
        .done       (done),
        .c_valid    (c_valid),
        .c_idx      (c_idx),
        .c_data     (c_data),
        .mac_output (mac_output),
        .ovf        (ovf),
        .c_flat     (c_flat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_c_valid"}, c_valid, 0);
        check({tag, "_c_idx"}, c_idx, 0);
        check({tag, "_c_data"}, c_data, 0);
        check({tag, "_mac_output"}, mac_output, 0);
        check({tag, "_ovf"}, ovf, 0);
        check({tag, "_c_flat"}, c_flat, 0);
    endtask

    // Model: C = A x B with exact integer sums; a job is 17 enabled cycles,
    // element e is written on enabled cycle 4(e+1), done on enabled cycle 17.
    task automatic run_job(input logic [31:0] a, input logic [31:0] b,
                           input int stall_at, input int stall_len, input bit noise);
        int          sum;
        int          exp_c[4];
        bit          wrap[4];
        bit          exp_ovf;
        bit          ovf_so_far;
        logic [63:0] exp_flat;
        int          t;
        int          e;
        bit          exp_v;
        exp_ovf  = 0;
        exp_flat = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                sum = 0;
                for (int k = 0; k < 2; k++)
                    sum += int'(a[(2*i+k)*DW +: DW]) * int'(b[(2*k+j)*DW +: DW]);
                exp_c[2*i+j] = sum % 65536;
                wrap[2*i+j]  = (sum >= 65536);
                exp_ovf      = exp_ovf | wrap[2*i+j];
                exp_flat[(2*i+j)*AW +: AW] = 16'(sum % 65536);
            end
        end
        a_flat = a;
        b_flat = b;
        start  = 1'b1;
        enable = 1'b1;
        tick();
        start = 1'b0;
        t = 0;
        for (int c = 1; c <= 17 + stall_len; c++) begin
            enable = !(c >= stall_at && c < stall_at + stall_len);
            if (noise) begin
                start  = (c == 5 || c == 17);
                a_flat = $urandom;
                b_flat = $urandom;
            end
            #1;
            if (enable) t++;
            exp_v = enable && (t % 4 == 0) && (t <= 16);
            check("busy", busy, 1);
            check("c_valid", c_valid, exp_v);
            check("done", done, enable && (t == 17));
            if (exp_v) begin
                e = t / 4 - 1;
                ovf_so_far = 0;
                for (int q = 0; q <= e; q++) ovf_so_far = ovf_so_far | wrap[q];
                check("c_idx", c_idx, e);
                check("c_data", c_data, exp_c[e]);
                check("mac_output", mac_output, exp_c[e]);
                check("ovf_running", ovf, ovf_so_far);
            end
            @(posedge clk);
            #1;
        end
        enable = 1'b1;
        start  = 1'b0;
        #1;
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_c_valid", c_valid, 0);
        check("final_ovf", ovf, exp_ovf);
        check("final_c_flat", c_flat, exp_flat);
        tick();
    endtask

    initial begin
        logic [31:0] a_ex, b_ex, all_ff;
        a_ex   = {8'd4, 8'd3, 8'd2, 8'd1};
        b_ex   = {8'd6, 8'd5, 8'd4, 8'd3};
        all_ff = 32'hFFFF_FFFF;

        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check_all_zero("reset");
        tick();

        run_job(a_ex, b_ex, 0, 0, 0);
        run_job(all_ff, all_ff, 0, 0, 0);
        run_job(a_ex, b_ex, 7, 3, 0);
        run_job(a_ex, b_ex, 0, 0, 1);

        // Abort a wrapping job mid-flight
        a_flat = all_ff;
        b_flat = all_ff;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        check("pre_reset_ovf", ovf, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check_all_zero("midjob_reset");
        for (int c = 0; c < 20; c++) begin
            if (done || c_valid || busy) check("post_reset_quiet", {done, c_valid, busy}, 0);
            tick();
        end
        run_job(a_ex, b_ex, 0, 0, 0);

        // Back-to-back: a wrapping job then a non-wrapping one
        run_job(all_ff, all_ff, 0, 0, 0);
        run_job(all_ff, {8'd1, 8'd0, 8'd2, 8'd3}, 0, 0, 0);

        for (int n = 0; n < 6; n++)
            run_job($urandom, $urandom, int'($urandom_range(1, 16)), int'($urandom_range(0, 3)), 1'(n % 2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mm2x2_sequencer.md
# mm2x2_sequencer

Control-plus-datapath block that computes a 2×2 unsigned matrix product C = A×B by time-multiplexing one shared multiply-accumulate unit. It sits between the operand source and the result consumer in the Matrix Multiply Accelerator, replacing hard-wired operand sequencing. Operands are latched on a start handshake, and results stream out per element. The full result matrix is also held for readback.

## Interface
- DATA_W, 8, operand element width (unsigned)
- ACC_W, 16, accumulator/result element width
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- enable  input  1  global advance; low freezes all state
- start  input  1  request; accepted only in IDLE with enable=1
- a_flat  input  4*DATA_W  A row-major, a00 in LSBs: {a11,a10,a01,a00}
- b_flat  input  4*DATA_W  B row-major, same packing
- busy  output  1  high from the cycle after acceptance through DONE
- done  output  1  one-cycle pulse in DONE
- c_valid  output  1  one-cycle pulse when an element is written
- c_idx  output  2  element index {i,j} accompanying c_valid
- c_data  output  ACC_W  element value accompanying c_valid
- mac_output  output  ACC_W  live accumulator value
- ovf  output  1  sticky; set if any accumulation wrapped this job
- c_flat  output  4*ACC_W  result matrix, same packing as a_flat

## Operation
- States: IDLE, CLEAR, MAC, WRITE, DONE.
- IDLE, start=1: latch a_flat/b_flat, i=j=0, clear ovf and c_flat → CLEAR.
- CLEAR: acc←0, k←0 → MAC.
- MAC: acc←acc + a[i][k]*b[k][j]; k=1 → WRITE, else k++.
- WRITE: c[i][j]←acc; c_valid=1, c_idx={i,j}, c_data=acc. If {i,j}=3 → DONE, else {i,j}++ (order 00,01,10,11) → CLEAR.
- DONE: done=1 → IDLE.
- Product is DATA_W×DATA_W → 2·DATA_W bits. Accumulation is modulo 2^ACC_W. A carry out of ACC_W sets ovf, which stays set until the next accepted start.
- start outside IDLE is ignored with no queuing, including start during DONE.
- Operand inputs may change freely after acceptance. Only the latched copies are used.
- enable=0 gates every register update. c_valid and done are decoded as state AND enable, so they are low while stalled and fire once when enable returns.

## Timing
- Reset (reset=0 at a clk edge) forces: state IDLE, busy=0, done=0, c_valid=0, c_idx=0, c_data=0, mac_output=0, ovf=0, c_flat=0. Latched operands are cleared.
- Reset mid-job aborts immediately with no done and no further c_valid. The next start begins a clean job.
- Latency with enable held high, where start is accepted at edge E0:
  - Each element takes 4 cycles (CLEAR, MAC, MAC, WRITE).
  - c_valid occurs in cycles 4, 8, 12, 16 after E0.
  - done occurs in cycle 17.
  - The next start is accepted no earlier than cycle 18.
  - Each stalled cycle adds exactly one cycle.
- c_flat[idx] updates at the edge ending WRITE and holds until the next accepted start.
- mac_output shows acc every cycle, including 0 after CLEAR.

## Structure
- Shared package mm_pkg holds the state typedef (IDLE…DONE), the DATA_W/ACC_W defaults, and the element index constants.
- One sub-module, mac_unit (clk, reset, en, clr, a, b → acc, ovf_pulse), containing the multiplier, adder, and wrap detection.
- The FSM, counters, operand latches, and result registers live in mm2x2_sequencer.

## Test plan
- A={1,2;3,4}, B={3,4;5,6}, start at cycle 0 → c_valid in cycles 4/8/12/16 with (idx,data) = (0,13), (1,16), (2,29), (3,36); done in cycle 17; ovf=0; c_flat = {36,29,16,13}.
- All operands 255 → every element equals 64514 (130050 mod 65536); ovf=1 after the first WRITE and held through done.
- Same job as the first, with enable low for 3 cycles during the second MAC of element 1 → values unchanged; c_valid for idx 1 in cycle 11; done in cycle 20; no pulses while stalled.
- start re-pulsed in cycles 5 and 17, and operands changed after acceptance → results identical to the first scenario; a second job begins only from a start in cycle 18.
- reset=0 in cycle 10 → all outputs 0 next cycle, no done; a fresh start completes normally with correct results.
- Back-to-back jobs with different B → the second job's ovf and c_flat reflect only the second job.
